// File: rtl/instr_fetch_unit.sv
// Fetch stage: next-PC select, in-order fetch queue, and redirect drain of stale responses.
// Define FETCH_PERF_EN to add the perf_fetch_cnt / perf_drop_cnt counters.
module instr_fetch_unit #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
`ifdef FETCH_PERF_EN
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_drop_cnt,
`endif
  input  logic [PC_W-1:0] pc_in,
  input  logic [PC_W-1:0] pc_plus1_in,
  output logic [PC_W-1:0] pc_next,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [PC_W-1:0] imem_rsp_data,
  output logic            ifid_valid,
  input  logic            ifid_ready,
  output logic [PC_W-1:0] ifid_instr,
  output logic [PC_W-1:0] ifid_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = AW + 2;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t          state;
  logic [PC_W-1:0] pc_q    [DEPTH];
  logic [PC_W-1:0] instr_q [DEPTH];
  logic [AW-1:0]   head, tail, fill_idx;
  logic [CW-1:0]   cnt, nfilled, unfilled;
  logic [DW-1:0]   drop_cnt, drop_nxt;
  logic            full, req_fire, pop, rsp_fill, rsp_drop;

  always_comb begin
    full           = (cnt == CW'(DEPTH));
    unfilled       = cnt - nfilled;
    fill_idx       = head + AW'(nfilled);
    imem_req_valid = !rst && !redirect_valid && !full;
    imem_req_addr  = pc_in;
    req_fire       = imem_req_valid && imem_req_ready;
    ifid_valid     = !rst && (nfilled != '0);
    ifid_pc        = pc_q[head];
    ifid_instr     = instr_q[head];
    pop            = ifid_valid && ifid_ready && !redirect_valid;
    rsp_drop       = imem_rsp_valid && (state == DRAIN);
    rsp_fill       = imem_rsp_valid && (state == RUN) && (unfilled != '0) && !redirect_valid;
    // A response landing with the redirect is itself stale and is consumed this cycle,
    // so it leaves one fewer response to discard later.
    drop_nxt = drop_cnt + DW'(unfilled);
    if (imem_rsp_valid && (drop_nxt != '0))
      drop_nxt = drop_nxt - DW'(1);
    pc_next = pc_in;
    if (rst)
      pc_next = pc_in;
    else if (redirect_valid)
      pc_next = redirect_pc;
    else if (req_fire)
      pc_next = pc_plus1_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      nfilled  <= '0;
      drop_cnt <= '0;
      state    <= RUN;
    end else if (redirect_valid) begin
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      nfilled  <= '0;
      drop_cnt <= drop_nxt;
      state    <= (drop_nxt != '0) ? DRAIN : RUN;
    end else begin
      tail    <= tail + AW'(req_fire);
      head    <= head + AW'(pop);
      cnt     <= cnt + CW'(req_fire) - CW'(pop);
      nfilled <= nfilled + CW'(rsp_fill) - CW'(pop);
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - DW'(1);
        if (drop_cnt == DW'(1))
          state <= RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire)
      pc_q[tail] <= pc_in;
    if (rsp_fill)
      instr_q[fill_idx] <= imem_rsp_data;
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (pop)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (imem_rsp_valid && ((state == DRAIN) || redirect_valid))
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: PC register and in-order 1-cycle memory modelled here.
module tb_instr_fetch_unit;
  localparam int          PC_W = 32;
  localparam logic [31:0] OFS  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_reg, pc_plus1, pc_next, redirect_pc, imem_req_addr, imem_rsp_data;
  logic [31:0] ifid_instr, ifid_pc;
  logic        redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        ifid_valid, ifid_ready, rsp_en;
  int          acc_cnt;
  logic [31:0] mq[$];
  logic [31:0] log_pc[$];
  logic [31:0] log_ins[$];
  int          n_cmp = 0;
  int          n_bad = 0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif

  always #5 clk = ~clk;
  assign pc_plus1 = pc_reg + 32'd1;

  instr_fetch_unit #(.DEPTH(2), .PC_W(PC_W)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt),
`endif
    .pc_in          (pc_reg),
    .pc_plus1_in    (pc_plus1),
    .pc_next        (pc_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ifid_valid     (ifid_valid),
    .ifid_ready     (ifid_ready),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc)
  );

  always @(posedge clk) begin
    if (rst) pc_reg <= '0;
    else     pc_reg <= pc_next;
  end

  // memory: instruction word = address + OFS, answered in order one cycle after accept
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
      acc_cnt        <= 0;
    end else begin
      if (rsp_en && mq.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mq.pop_front() + OFS;
      end else begin
        imem_rsp_valid <= 1'b0;
      end
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back(imem_req_addr);
        acc_cnt <= acc_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && ifid_valid && ifid_ready && !redirect_valid) begin
      log_pc.push_back(ifid_pc);
      log_ins.push_back(ifid_instr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    log_pc.delete();
    log_ins.delete();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_log(input int n, input string tag);
    int k = 0;
    while (log_pc.size() < n && k < 50) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk({tag, "_delivered"}, 32'(log_pc.size() >= n), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset: redirect asserted during reset must be ignored
    redirect_valid = 1'b1;
    redirect_pc    = 32'h99;
    imem_req_ready = 1'b1;
    ifid_ready     = 1'b1;
    rsp_en         = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_ifid_valid", 32'(ifid_valid), 32'd0);
    chk("rst_pc_next", pc_next, 32'd0);

    // sequential fetch with decode always ready
    do_reset();
    chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_addr_0", imem_req_addr, 32'd0);
    chk("t1_pc_next_0", pc_next, 32'd1);
    @(negedge clk); #1;
    chk("t1_addr_1", imem_req_addr, 32'd1);
    chk("t1_pc_next_1", pc_next, 32'd2);
    wait_log(4, "t1");
    for (int i = 0; i < 4; i++) begin
      if (log_pc.size() > i) begin
        chk("t1_ifid_pc", log_pc[i], 32'(i));
        chk("t1_ifid_instr", log_ins[i], 32'(i) + OFS);
      end
    end

    // memory stalls 3 cycles, then decode stalled until the queue fills
    imem_req_ready = 1'b0;
    ifid_ready     = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("t5_req_valid", 32'(imem_req_valid), 32'd1);
      chk("t5_addr", imem_req_addr, 32'd0);
      chk("t5_pc_next", pc_next, 32'd0);
      @(negedge clk); #1;
    end
    chk("t5_no_accept", 32'(acc_cnt), 32'd0);
    imem_req_ready = 1'b1;
    #1;
    chk("t2_pc_next_fire", pc_next, 32'd1);
    repeat (6) @(negedge clk);
    #1;
    chk("t2_req_valid_full", 32'(imem_req_valid), 32'd0);
    chk("t2_pc_next_hold", pc_next, 32'd2);
    chk("t2_pc_in", pc_reg, 32'd2);
    chk("t2_accepted", 32'(acc_cnt), 32'd2);
    chk("t2_ifid_valid", 32'(ifid_valid), 32'd1);
    chk("t2_ifid_pc", ifid_pc, 32'd0);
    chk("t2_ifid_instr", ifid_instr, OFS);

    // redirect with two fetches outstanding
    ifid_ready = 1'b1;
    rsp_en     = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    chk("t3_pc_next_redirect", pc_next, 32'h40);
    chk("t3_req_valid_redirect", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    rsp_en         = 1'b1;
    #1;
    chk("t3_pc_in", pc_reg, 32'h40);
    wait_log(2, "t3");
    if (log_pc.size() >= 2) begin
      chk("t3_ifid_pc0", log_pc[0], 32'h40);
      chk("t3_ifid_instr0", log_ins[0], 32'h40 + OFS);
      chk("t3_ifid_pc1", log_pc[1], 32'h41);
      chk("t3_ifid_instr1", log_ins[1], 32'h41 + OFS);
    end
`ifdef FETCH_PERF_EN
    chk("t3_perf_drop", perf_drop_cnt, 32'd2);
    chk("t3_perf_fetch", perf_fetch_cnt, 32'(log_pc.size()));
`endif

    // redirect in the same cycle as the first response
    do_reset();
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    #1;
    chk("t4_ifid_valid_redirect", 32'(ifid_valid), 32'd0);
    chk("t4_pc_next_redirect", pc_next, 32'h80);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("t4_ifid_valid_after", 32'(ifid_valid), 32'd0);
    wait_log(1, "t4");
    if (log_pc.size() >= 1) begin
      chk("t4_ifid_pc0", log_pc[0], 32'h80);
      chk("t4_ifid_instr0", log_ins[0], 32'h80 + OFS);
    end
`ifdef FETCH_PERF_EN
    chk("t4_perf_drop", perf_drop_cnt, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
